// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit:
// operation encodings, FSM state type and small opcode decode helpers.
package mdu_iter_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU: the iterative operations
  function automatic logic op_is_calc(input logic [MDU_OP_W-1:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_signed(input logic [MDU_OP_W-1:0] op);
    return (op[2] == 1'b0) && (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between the execute stage and the MDU.
//   start/op/a/b/flush : requester -> MDU
//   busy/done/div0/hi/lo : MDU -> requester (all registered in the MDU)
interface mdu_iter_if #(
  parameter int WIDTH = 32
) ();
  import mdu_iter_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] op;
  logic [WIDTH-1:0]    a;
  logic [WIDTH-1:0]    b;
  logic                flush;
  logic                busy;
  logic                done;
  logic                div0;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mdu_iter_negate.sv
// Conditional two's-complement: out = neg ? -in : in.
// Used for operand magnitudes and for result sign fix-up.
//   in  : WIDTH-bit value
//   neg : negate when 1
//   out : WIDTH-bit result
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = in;
    if (neg) out = ~in + WIDTH'(1);
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, followed by a sign fix-up.
// Owns the architectural HI/LO registers (MTHI/MTLO write them directly).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mdu_iter_if (start/op/a/b/flush in,
//                busy/done/div0/hi/lo out)
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_iter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e state, state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] sh;        // {rem,quo} or {prod_hi,prod_lo}
  logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               div0_pend;
  logic               fix_ph;
  logic               busy_r;
  logic               done_r;
  logic               div0_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               idle_ok;
  logic               accept;
  logic               mt_wr;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fixed;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_nx;

  // busy lags the FSM by one cycle so it still reads 1 on the done cycle;
  // acceptance therefore needs both IDLE and busy low.
  assign idle_ok = (state == ST_IDLE) && !busy_r && bus.start && !bus.flush;
  assign accept  = idle_ok && op_is_calc(bus.op);
  assign mt_wr   = idle_ok && ((bus.op == MDU_MTHI) || (bus.op == MDU_MTLO));

  mdu_negate #(.WIDTH(WIDTH)) u_abs_a (
    .in (bus.a),
    .neg(op_is_signed(bus.op) && bus.a[WIDTH-1]),
    .out(abs_a)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_abs_b (
    .in (bus.b),
    .neg(op_is_signed(bus.op) && bus.b[WIDTH-1]),
    .out(abs_b)
  );

  mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .in (sh),
    .neg(neg_lo),
    .out(prod_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .in (sh[WIDTH-1:0]),
    .neg(neg_lo),
    .out(quo_fix)
  );

  mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .in (sh[2*WIDTH-1:WIDTH]),
    .neg(neg_hi),
    .out(rem_fix)
  );

  // One iteration step and the sign-corrected result
  always_comb begin
    mul_sum   = {1'b0, sh[2*WIDTH-1:WIDTH]} + {1'b0, (sh[0] ? opnd : {WIDTH{1'b0}})};
    div_trial = sh[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    step_nx   = {mul_sum, sh[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH]) step_nx = {div_trial[WIDTH-1:0], sh[WIDTH-2:0], 1'b1};
      else                   step_nx = {sh[2*WIDTH-2:0], 1'b0};
    end
    fixed = prod_fix;
    if (is_div) fixed = {rem_fix, (div0_pend ? {WIDTH{1'b1}} : quo_fix)};
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_CALC;
      ST_CALC: if (cnt == '0) state_nx = ST_FIX;
      ST_FIX:  if (fix_ph) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (bus.flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FIX spends two cycles: the first registers the 2*WIDTH negation so the
  // long carry chain does not feed the HI/LO write directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      opnd      <= '0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div0_pend <= 1'b0;
      fix_ph    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      div0_r    <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
    end else begin
      done_r <= 1'b0;
      busy_r <= !bus.flush && (state != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            is_div    <= op_is_div(bus.op);
            sh        <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? abs_a : abs_b)};
            opnd      <= op_is_div(bus.op) ? abs_b : abs_a;
            neg_lo    <= op_is_signed(bus.op) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_hi    <= op_is_signed(bus.op) && bus.a[WIDTH-1];
            div0_pend <= op_is_div(bus.op) && (bus.b == '0);
            cnt       <= CNT_W'(WIDTH - 1);
            fix_ph    <= 1'b0;
          end else if (mt_wr) begin
            if (bus.op == MDU_MTHI) hi_r <= bus.a;
            else                    lo_r <= bus.a;
            done_r <= 1'b1;
          end
        end
        ST_CALC: begin
          if (!bus.flush) begin
            sh  <= step_nx;
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (!bus.flush) begin
            if (!fix_ph) begin
              sh     <= fixed;
              fix_ph <= 1'b1;
            end else begin
              hi_r   <= sh[2*WIDTH-1:WIDTH];
              lo_r   <= sh[WIDTH-1:0];
              div0_r <= div0_pend;
              done_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    bit           chk_div0;
    string        name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse pops and compares the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done hi=%h lo=%h (no result expected)", bus.hi, bus.lo);
        end else begin
          e = exp_q.pop_front();
          if (bus.hi !== e.hi || bus.lo !== e.lo || (e.chk_div0 && bus.div0 !== e.div0)) begin
            failures++;
            $display("FAIL %s got hi=%h lo=%h div0=%b expected hi=%h lo=%h div0=%b",
                     e.name, bus.hi, bus.lo, bus.div0, e.hi, e.lo, e.div0);
          end
        end
      end
    end
  end

  function automatic exp_t mk(input logic [W-1:0] hi, input logic [W-1:0] lo,
                              input logic d0, input bit chk, input string nm);
    exp_t e;
    e.hi = hi; e.lo = lo; e.div0 = d0; e.chk_div0 = chk; e.name = nm;
    return e;
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns #1 after accept edge
  task automatic drive(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(input int max_cyc, output bit got, output int n);
    n = 0;
    got = 1'b0;
    while (n < max_cyc) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (bus.busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got busy/done/div0=%b%b%b expected 000", bus.busy, bus.done, bus.div0);
    end
    checks++;
    if (bus.hi !== '0 || bus.lo !== '0) begin
      failures++;
      $display("FAIL reset_hilo got hi=%h lo=%h expected 0/0", bus.hi, bus.lo);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    bit got;
    int n;
    exp_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, "mult_m3x7"));
    drive(MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(60, got, n);
    checks++;
    if (!got || n != W + 2) begin
      failures++;
      $display("FAIL mult_latency got=%0d done_seen=%0b expected=%0d", n, got, W + 2);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_on_done got=%b expected 1", bus.busy);
    end
    wait_idle();
    exp_q.push_back(mk(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, "multu_max"));
    drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(60, got, n);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL multu_timeout got no done expected done");
    end
    wait_idle();
  endtask

  task automatic test_div();
    bit got;
    int n;
    logic [W-1:0] av[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h1234};
    logic [W-1:0] bv[4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
    mdu_op_e      ov[4] = '{MDU_DIV, MDU_DIVU, MDU_DIV, MDU_DIVU};
    logic [W-1:0] hv[4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1234};
    logic [W-1:0] lv[4] = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    logic         dv[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    string        nv[4] = '{"div_m7_2", "divu_7_2", "div_min_m1", "divu_by0"};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(hv[i], lv[i], dv[i], 1'b1, nv[i]));
      drive(ov[i], av[i], bv[i]);
      wait_done(60, got, n);
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL %s_timeout got no done expected done", nv[i]);
      end
      wait_idle();
    end
  endtask

  // Prior HI/LO come from divu_by0: hi=1234, lo=FFFFFFFF
  task automatic test_flush();
    int dones = 0;
    drive(MDU_MULT, 32'd3, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy got=%b expected 0", bus.busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (bus.done) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL flush_no_done got=%0d expected 0", dones);
    end
    checks++;
    if (bus.hi !== 32'h1234 || bus.lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL flush_hold got hi=%h lo=%h expected 00001234/ffffffff", bus.hi, bus.lo);
    end
    bus.flush = 1'b1;
    drive(MDU_MTLO, 32'h55, 32'd0);
    bus.flush = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.lo !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL mtlo_flush got done=%b lo=%h expected 0/ffffffff", bus.done, bus.lo);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit got;
    int n;
    exp_q.push_back(mk(32'hA5, 32'hFFFF_FFFF, 1'b0, 1'b0, "mthi_a5"));
    drive(MDU_MTHI, 32'hA5, 32'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.hi !== 32'hA5) begin
      failures++;
      $display("FAIL mthi_same_edge got done=%b busy=%b hi=%h expected 1/0/000000a5",
               bus.done, bus.busy, bus.hi);
    end
    @(posedge clk); #1;
    // start held through done: first accept now, second only once IDLE again
    exp_q.push_back(mk(32'd0, 32'd42, 1'b0, 1'b0, "mult_held_1"));
    exp_q.push_back(mk(32'd0, 32'd42, 1'b0, 1'b0, "mult_held_2"));
    bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clk); #1;
    wait_done(60, got, n);
    checks++;
    if (!got || n != W + 2) begin
      failures++;
      $display("FAIL held_first_latency got=%0d done_seen=%0b expected=%0d", n, got, W + 2);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL held_gap got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(60, got, n);
    checks++;
    if (!got || n != W + 2) begin
      failures++;
      $display("FAIL held_second_latency got=%0d done_seen=%0b expected=%0d", n, got, W + 2);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_calc();
    drive(MDU_MULTU, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      failures++;
      $display("FAIL reset_mid_calc got busy=%b done=%b hi=%h lo=%h expected 0/0/0/0",
               bus.busy, bus.done, bus.hi, bus.lo);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results got=%0d expected 0", exp_q.size());
    end
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
